proc_issue_ctrl: RTL and testbench

// - Parametrised successor to the processor top-level glue for the 10-instruction processor.
// - Accepts host instructions (opcode, dst, src, srcIsImm) on a valid/ready port and encodes them into instruction words.
// - Buffers encoded words in a QDEPTH FIFO and issues them to the cpu core one at a time over a handshake.
// - Arbitrates the single RAM port between cpu and host readback. After STR/BRA/HLT retire, it reads RAM[dst] and returns Res/resvalid.

---
 rtl/proc_issue_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_proc_issue_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : proc_issue_ctrl
// Description : Issue controller for the 10-instruction processor.
//               Host instructions arrive on a valid/ready port and are
//               encoded into 32-bit instruction words. The words are queued
//               in a QDEPTH-entry FIFO and issued to the cpu core one at a
//               time. The controller also arbitrates the single RAM port.
//               After STR/BRA/HLT retire, it reads RAM[dst] back to the host.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid / in_ready   host instruction handshake
//   Opcode, DstOp, SrcOp, srcIsImm   host instruction fields
//   ir_valid / ir_ready   issue handshake to the cpu
//   IReg                  encoded instruction presented to the cpu
//   cpu_done              cpu retired the issued instruction (1-cycle pulse)
//   cpu_mrwen, cpu_mind   cpu RAM request (honoured only while executing)
//   mem_mrwen, mem_ind    RAM port after arbitration
//   mem_rdata             RAM read data, MEM_LAT cycles after mem_ind
//   Res / resvalid        readback data and its 1-cycle strobe
//   halted                HLT has retired; sticky until reset
// ============================================================================
module proc_issue_ctrl #(
    parameter int BUSW    = 32,
    parameter int PSRW    = 5,
    parameter int MINDW   = 12,
    parameter int QDEPTH  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Opcode,
    input  logic [BUSW-1:0]  DstOp,
    input  logic [BUSW-1:0]  SrcOp,
    input  logic             srcIsImm,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [31:0]      IReg,
    input  logic             cpu_done,
    input  logic             cpu_mrwen,
    input  logic [MINDW-1:0] cpu_mind,
    output logic             mem_mrwen,
    output logic [MINDW-1:0] mem_ind,
    input  logic [BUSW-1:0]  mem_rdata,
    output logic [BUSW-1:0]  Res,
    output logic             resvalid,
    output logic             halted
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int C_CNT_W = C_PTR_W + 1;
    // The instruction word has fixed 12-bit src/dst fields.
    localparam int C_FLD_W = (MINDW < 12) ? MINDW : 12;
    // PSR width is carried for interface compatibility only.
    localparam int C_UNUSED_PSRW = PSRW;

    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(QDEPTH);
    localparam logic [2:0]         C_LAT     = 3'(MEM_LAT);

    localparam logic [2:0] C_S_IDLE    = 3'd0;
    localparam logic [2:0] C_S_ISSUE   = 3'd1;
    localparam logic [2:0] C_S_EXEC    = 3'd2;
    localparam logic [2:0] C_S_RB_REQ  = 3'd3;
    localparam logic [2:0] C_S_RB_WAIT = 3'd4;
    localparam logic [2:0] C_S_HALT    = 3'd5;

    localparam logic [3:0] C_OP_NOP = 4'd0;
    localparam logic [3:0] C_OP_LD  = 4'd1;
    localparam logic [3:0] C_OP_STR = 4'd2;
    localparam logic [3:0] C_OP_BRA = 4'd3;
    localparam logic [3:0] C_OP_XOR = 4'd4;
    localparam logic [3:0] C_OP_ADD = 4'd5;
    localparam logic [3:0] C_OP_ROT = 4'd6;
    localparam logic [3:0] C_OP_SHF = 4'd7;
    localparam logic [3:0] C_OP_HLT = 4'd8;
    localparam logic [3:0] C_OP_CMP = 4'd9;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]         state_q,    state_d;
    logic [C_PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [C_CNT_W-1:0] count_q,    count_d;
    logic [31:0]        ireg_q,     ireg_d;
    logic               rb_q,       rb_d;
    logic [MINDW-1:0]   dst_q,      dst_d;
    logic [2:0]         lat_q,      lat_d;
    logic [BUSW-1:0]    res_q,      res_d;
    logic               resvalid_q, resvalid_d;

    logic [31:0]        fifo_word_q [QDEPTH];
    logic               fifo_rb_q   [QDEPTH];
    logic [MINDW-1:0]   fifo_dst_q  [QDEPTH];

    logic [11:0]        w_src_fld;
    logic [11:0]        w_dst_fld;
    logic [31:0]        w_enc;
    logic               w_enc_rb;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_is_hlt;
    logic               w_unused;

    // Upper operand bits are ignored by design.
    assign w_unused = &{1'b0, SrcOp, DstOp};

    // ------------------------------------------------------------------------
    // Instruction encoder
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_fld                = '0;
        w_dst_fld                = '0;
        w_src_fld[C_FLD_W-1:0]   = SrcOp[C_FLD_W-1:0];
        w_dst_fld[C_FLD_W-1:0]   = DstOp[C_FLD_W-1:0];
        w_enc                    = 32'h0;
        case (Opcode)
            C_OP_LD, C_OP_STR, C_OP_XOR, C_OP_ADD:
                w_enc = {Opcode, srcIsImm, 1'b0, 2'b00, w_src_fld, w_dst_fld};
            // Rotate/shift amounts are always immediates.
            C_OP_ROT, C_OP_SHF:
                w_enc = {Opcode, 1'b1, 1'b0, 2'b00, w_src_fld, w_dst_fld};
            // Branch carries a 3-bit condition code in [26:24] and a target.
            C_OP_BRA:
                w_enc = {Opcode, 1'b0, SrcOp[2:0], 12'h000, w_dst_fld};
            // Compare flags its immediate in the dstT position.
            C_OP_CMP:
                w_enc = {Opcode, 1'b0, srcIsImm, 2'b00, w_src_fld, w_dst_fld};
            C_OP_HLT:
                w_enc = {Opcode, 28'h0};
            C_OP_NOP:
                w_enc = 32'h0;
            default:
                w_enc = 32'h0;
        endcase
        w_enc_rb = (Opcode == C_OP_STR) || (Opcode == C_OP_BRA) ||
                   (Opcode == C_OP_HLT);
    end

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    assign w_full   = (count_q == C_DEPTH);
    assign w_pop    = (state_q == C_S_IDLE) && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push   = in_valid && in_ready;
    assign w_is_hlt = (ireg_q[31:28] == C_OP_HLT);

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_word_q[wr_ptr_q] <= w_enc;
            fifo_rb_q[wr_ptr_q]   <= w_enc_rb;
            fifo_dst_q[wr_ptr_q]  <= DstOp[MINDW-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= C_S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ireg_q     <= 32'h0;
            rb_q       <= 1'b0;
            dst_q      <= '0;
            lat_q      <= 3'd0;
            res_q      <= '0;
            resvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ireg_q     <= ireg_d;
            rb_q       <= rb_d;
            dst_q      <= dst_d;
            lat_q      <= lat_d;
            res_q      <= res_d;
            resvalid_q <= resvalid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ireg_d     = ireg_q;
        rb_d       = rb_q;
        dst_d      = dst_q;
        lat_d      = lat_q;
        res_d      = res_q;
        resvalid_d = 1'b0;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            C_S_IDLE: begin
                if (w_pop) begin
                    ireg_d  = fifo_word_q[rd_ptr_q];
                    rb_d    = fifo_rb_q[rd_ptr_q];
                    dst_d   = fifo_dst_q[rd_ptr_q];
                    state_d = C_S_ISSUE;
                end
            end
            C_S_ISSUE: begin
                if (ir_ready) begin
                    state_d = C_S_EXEC;
                end
            end
            C_S_EXEC: begin
                if (cpu_done) begin
                    if (rb_q) begin
                        lat_d   = C_LAT;
                        state_d = C_S_RB_REQ;
                    end else if (w_is_hlt) begin
                        state_d = C_S_HALT;
                    end else begin
                        state_d = C_S_IDLE;
                    end
                end
            end
            // The address goes out in RB_REQ; data is captured once the
            // counter, started at MEM_LAT in this cycle, reaches zero.
            C_S_RB_REQ: begin
                lat_d   = lat_q - 3'd1;
                state_d = C_S_RB_WAIT;
            end
            C_S_RB_WAIT: begin
                if (lat_q == 3'd0) begin
                    res_d      = mem_rdata;
                    resvalid_d = 1'b1;
                    state_d    = w_is_hlt ? C_S_HALT : C_S_IDLE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            C_S_HALT: begin
                state_d = C_S_HALT;
            end
            default: begin
                state_d = C_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (!w_full || w_pop) && (state_q != C_S_HALT);
        ir_valid  = (state_q == C_S_ISSUE);
        IReg      = ireg_q;
        Res       = res_q;
        resvalid  = resvalid_q;
        halted    = (state_q == C_S_HALT);
        mem_mrwen = 1'b0;
        mem_ind   = '0;
        case (state_q)
            C_S_EXEC: begin
                mem_mrwen = cpu_mrwen;
                mem_ind   = cpu_mind;
            end
            C_S_RB_REQ, C_S_RB_WAIT: begin
                mem_ind = dst_q;
            end
            default: begin
                mem_mrwen = 1'b0;
                mem_ind   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_proc_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_issue_ctrl
// Description : Self-checking bench for proc_issue_ctrl (MEM_LAT=2, QDEPTH=4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_issue_ctrl;

    localparam int BUSW    = 32;
    localparam int MINDW   = 12;
    localparam int QDEPTH  = 4;
    localparam int MEM_LAT = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       Opcode = 4'd0;
    logic [BUSW-1:0]  DstOp = '0;
    logic [BUSW-1:0]  SrcOp = '0;
    logic             srcIsImm = 1'b0;
    logic             ir_valid;
    logic             ir_ready = 1'b0;
    logic [31:0]      IReg;
    logic             cpu_done = 1'b0;
    logic             cpu_mrwen = 1'b0;
    logic [MINDW-1:0] cpu_mind = '0;
    logic             mem_mrwen;
    logic [MINDW-1:0] mem_ind;
    logic [BUSW-1:0]  mem_rdata;
    logic [BUSW-1:0]  Res;
    logic             resvalid;
    logic             halted;

    int checks = 0;
    int errors = 0;

    proc_issue_ctrl #(
        .BUSW(BUSW), .PSRW(5), .MINDW(MINDW), .QDEPTH(QDEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .DstOp(DstOp), .SrcOp(SrcOp), .srcIsImm(srcIsImm),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .IReg(IReg),
        .cpu_done(cpu_done), .cpu_mrwen(cpu_mrwen), .cpu_mind(cpu_mind),
        .mem_mrwen(mem_mrwen), .mem_ind(mem_ind), .mem_rdata(mem_rdata),
        .Res(Res), .resvalid(resvalid), .halted(halted)
    );

    always #5 clk = ~clk;

    // RAM with a 2-cycle read latency
    logic [BUSW-1:0]  ram [0:4095];
    logic [MINDW-1:0] p0 = '0;
    logic [MINDW-1:0] p1 = '0;
    always @(posedge clk) begin
        p0 <= mem_ind;
        p1 <= p0;
    end
    assign mem_rdata = ram[p1];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] dst;
        logic [31:0] src;
        logic        imm;
        logic [31:0] exp_ir;
        int          exp_nres;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] dst,
                          input logic [31:0] src, input logic imm);
        Opcode   = op;
        DstOp    = dst;
        SrcOp    = src;
        srcIsImm = imm;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [3:0] op, input logic [31:0] dst,
                        input logic [31:0] src, input logic imm);
        int n;
        n = 0;
        set_in(op, dst, src, imm);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_irv(input string name);
        int n;
        n = 0;
        while (!ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ir_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: ir_valid timeout got 0 expected 1", name);
        end
    endtask

    // Accept IReg for one cycle, then retire it with a cpu_done pulse.
    task automatic fire();
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
    endtask

    task automatic count_res(input int cycles, output int n, output logic [31:0] last);
        n    = 0;
        last = 32'h0;
        repeat (cycles) begin
            if (resvalid) begin
                n++;
                last = Res;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          seen;
        logic [31:0] r;
        logic [31:0] w;

        for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE_0000 | i;
        ram[12'h020] = 32'hDEAD_BEEF;

        vt[0] = '{4'd5,  32'h010,       32'h005,       1'b1, 32'h5800_5010, 0, 32'h0};
        vt[1] = '{4'd1,  32'h123,       32'h456,       1'b0, 32'h1045_6123, 0, 32'h0};
        vt[2] = '{4'd4,  32'hFFFF_FFFF, 32'h1234_5ABC, 1'b1, 32'h48AB_CFFF, 0, 32'h0};
        vt[3] = '{4'd6,  32'h001,       32'h003,       1'b0, 32'h6800_3001, 0, 32'h0};
        vt[4] = '{4'd7,  32'h002,       32'h007,       1'b1, 32'h7800_7002, 0, 32'h0};
        vt[5] = '{4'd9,  32'h030,       32'h040,       1'b1, 32'h9404_0030, 0, 32'h0};
        vt[6] = '{4'd3,  32'h055,       32'h00D,       1'b1, 32'h3500_0055, 1, 32'hC0DE_0055};
        vt[7] = '{4'd0,  32'h111,       32'h222,       1'b1, 32'h0000_0000, 0, 32'h0};
        vt[8] = '{4'd12, 32'h333,       32'h444,       1'b1, 32'h0000_0000, 0, 32'h0};
        vt[9] = '{4'd2,  32'h020,       32'h00F,       1'b1, 32'h2800_F020, 1, 32'hDEAD_BEEF};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ireg", IReg, 0);
        chk("rst_resvalid", resvalid, 0);
        chk("rst_res", Res, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mrwen", mem_mrwen, 0);
        chk("rst_mind", mem_ind, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // cpu cannot write RAM while idle
        cpu_mrwen = 1'b1;
        cpu_mind  = 12'h155;
        #1;
        chk("idle_mrwen", mem_mrwen, 0);
        chk("idle_mind", mem_ind, 0);
        cpu_mrwen = 1'b0;
        @(negedge clk);

        // ---------------- ADD: hold and cpu RAM tracking ----------------
        push(4'd5, 32'h010, 32'h005, 1'b1);
        wait_irv("add");
        chk("add_ireg", IReg, 32'h5800_5010);
        repeat (3) @(negedge clk);
        chk("add_hold_valid", ir_valid, 1);
        chk("add_hold_ireg", IReg, 32'h5800_5010);
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready  = 1'b0;
        cpu_mrwen = 1'b1;
        cpu_mind  = 12'h0AB;
        #1;
        chk("exec_mrwen1", mem_mrwen, 1);
        chk("exec_mind1", mem_ind, 12'h0AB);
        cpu_mrwen = 1'b0;
        cpu_mind  = 12'h3C4;
        #1;
        chk("exec_mrwen0", mem_mrwen, 0);
        chk("exec_mind2", mem_ind, 12'h3C4);
        @(negedge clk);
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        count_res(8, n, r);
        chk("add_nres", n, 0);

        // ---------------- STR: exact readback timing ----------------
        push(4'd2, 32'h020, 32'h000, 1'b0);
        wait_irv("str");
        chk("str_ireg", IReg, 32'h2000_0020);
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready  = 1'b0;
        cpu_done  = 1'b1;
        cpu_mrwen = 1'b1;
        cpu_mind  = 12'h7FF;
        @(negedge clk);
        cpu_done = 1'b0;
        chk("str_rbreq_mind", mem_ind, 12'h020);
        chk("str_rbreq_mrwen", mem_mrwen, 0);
        chk("str_rv0", resvalid, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("str_rv%0d", k), resvalid, (k == 3) ? 1 : 0);
            if (k == 3) chk("str_res", Res, 32'hDEAD_BEEF);
        end
        cpu_mrwen = 1'b0;

        // ---------------- encoding table ----------------
        for (int i = 0; i < 10; i++) begin
            push(vt[i].op, vt[i].dst, vt[i].src, vt[i].imm);
            wait_irv($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ireg", i), IReg, vt[i].exp_ir);
            fire();
            count_res(8, n, r);
            chk($sformatf("vec%0d_nres", i), n, vt[i].exp_nres);
            if (vt[i].exp_nres != 0) chk($sformatf("vec%0d_res", i), r, vt[i].exp_res);
        end

        // ---------------- FIFO full, push+pop when full, wrap ----------------
        ir_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(4'd5, i + 1, 32'h10 + i, 1'b1);
            in_valid = 1'b1;
            #1;
            chk($sformatf("full_rdy%0d", i), in_ready, (i < 5) ? 1 : 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_irv("fifo0");
        chk("fifo_ireg0", IReg, 32'h5801_0001);
        fire();
        // Idle with a full FIFO: the pop this cycle frees the slot for word 5
        set_in(4'd5, 6, 32'h15, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("pushpop_full_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_again_rdy", in_ready, 0);
        for (int k = 1; k < 6; k++) begin
            wait_irv($sformatf("fifo%0d", k));
            w = 32'h5800_0000 | ((32'h10 + k) << 12) | (k + 1);
            chk($sformatf("fifo_ireg%0d", k), IReg, w);
            fire();
        end
        repeat (3) @(negedge clk);
        chk("fifo_drained", ir_valid, 0);

        // ---------------- HLT with a queued ADD ----------------
        push(4'd8, 32'h077, 32'h999, 1'b1);
        push(4'd5, 32'h010, 32'h005, 1'b1);
        wait_irv("hlt");
        chk("hlt_ireg", IReg, 32'h8000_0000);
        fire();
        count_res(8, n, r);
        chk("hlt_nres", n, 1);
        chk("hlt_res", r, 32'hC0DE_0077);
        chk("hlt_halted", halted, 1);
        chk("hlt_in_ready", in_ready, 0);
        cpu_mrwen = 1'b1;
        #1;
        chk("hlt_mrwen", mem_mrwen, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ir_valid) seen++;
        end
        chk("hlt_no_issue", seen, 0);
        cpu_mrwen = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_halted", halted, 0);
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // ---------------- reset during RB_WAIT ----------------
        push(4'd2, 32'h020, 32'h000, 1'b0);
        push(4'd5, 32'h010, 32'h005, 1'b1);
        wait_irv("abort");
        fire();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ir_valid", ir_valid, 0);
        chk("abort_ireg", IReg, 0);
        chk("abort_resvalid", resvalid, 0);
        chk("abort_res", Res, 0);
        chk("abort_halted", halted, 0);
        chk("abort_mrwen", mem_mrwen, 0);
        chk("abort_mind", mem_ind, 0);
        rst_n = 1'b1;
        seen = 0;
        n    = 0;
        repeat (8) begin
            @(negedge clk);
            if (ir_valid) seen++;
            if (resvalid) n++;
        end
        chk("abort_no_issue", seen, 0);
        chk("abort_no_res", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
